// File: rtl/dmem_wbuf.sv
// dmem_wbuf: data memory with a DEPTH-entry posted-store FIFO that drains one word per cycle.
// Define DMEM_FWD_EN for store-to-load forwarding; without it, a load that hits the FIFO stalls.
module dmem_wbuf #(
    parameter int DEPTH     = 8,
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        vwe,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] vwd_0,
    input  logic [31:0] vwd_1,
    input  logic [31:0] vwd_2,
    input  logic [31:0] vwd_3,
    input  logic [31:0] vwd_4,
    output logic [31:0] rd,
    output logic        stall,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int SW = CW + 3;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      mem_q  [MEM_WORDS];
    logic [31:0]      lane   [5];
    logic [PW-1:0]    off    [DEPTH];
    logic [DEPTH-1:0] hit;
    logic [AW-1:0]    a_w;
    logic [2:0]       need;
    logic             accept, drain, full, unused_a;

    assign a_w      = a[AW+1:2];
    assign unused_a = ^{a[31:AW+2], a[1:0]};
    assign lane     = '{vwe ? vwd_0 : wd, vwd_1, vwd_2, vwd_3, vwd_4};
    assign need     = vwe ? 3'd5 : (we ? 3'd1 : 3'd0);
    assign drain    = count_q != '0;
    assign empty    = !drain;
    assign full     = SW'(count_q) + SW'(need) > SW'(DEPTH);
    assign accept   = need != 3'd0 && !stall;
    assign head_d   = drain ? head_q + 1'b1 : head_q;
    assign tail_d   = accept ? tail_q + PW'(need) : tail_q;
    assign count_d  = count_q + (accept ? CW'(need) : '0) - CW'(drain);

    // An entry is live when its distance from head is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            off[i] = PW'(i) - head_q;
            hit[i] = {1'b0, off[i]} < count_q && addr_q[i] == a_w;
        end
    end

`ifdef DMEM_FWD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rd = mem_q[a_w];
        for (int k = 0; k < DEPTH; k++)
            if (hit[head_q + PW'(k)]) rd = data_q[head_q + PW'(k)];
    end
    assign stall = full;
`else
    assign rd    = mem_q[a_w];
    assign stall = full || |hit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (drain) mem_q[addr_q[head_q]] <= data_q[head_q];
        for (int j = 0; j < 5; j++)
            if (accept && 3'(j) < need) begin
                addr_q[tail_q + PW'(j)] <= a_w + AW'(j);
                data_q[tail_q + PW'(j)] <= lane[j];
            end
    end
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed and random stores/loads against a queue-based memory model.
`timescale 1ns/1ps
module tb_dmem_wbuf;
    localparam int DEPTH = 8;
    localparam int MW    = 64;

    typedef struct {
        int unsigned w;
        logic [31:0] d;
    } ent_t;

    logic        clk = 0, reset = 1, we = 0, vwe = 0;
    logic [31:0] a = 0, wd = 0;
    logic [31:0] vwd [5];
    logic [31:0] rd;
    logic        stall, empty;
    int          n_chk = 0, n_fail = 0;
    ent_t        fq[$];
    logic [31:0] mm [MW];
    bit          kn [MW];

    dmem_wbuf #(.DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .we(we), .vwe(vwe), .a(a), .wd(wd),
        .vwd_0(vwd[0]), .vwd_1(vwd[1]), .vwd_2(vwd[2]), .vwd_3(vwd[3]), .vwd_4(vwd[4]),
        .rd(rd), .stall(stall), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic int unsigned word_of(logic [31:0] addr);
        return (addr >> 2) % MW;
    endfunction

    function automatic int need_of();
        return vwe ? 5 : (we ? 1 : 0);
    endfunction

    function automatic bit exp_stall();
        bit s = fq.size() + need_of() > DEPTH;
`ifndef DMEM_FWD_EN
        foreach (fq[i]) if (fq[i].w == word_of(a)) s = 1;
`endif
        return s;
    endfunction

    function automatic bit exp_rd(output logic [31:0] v);
`ifdef DMEM_FWD_EN
        for (int i = fq.size() - 1; i >= 0; i--)
            if (fq[i].w == word_of(a)) begin
                v = fq[i].d;
                return 1;
            end
`endif
        v = mm[word_of(a)];
        return kn[word_of(a)];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outs(string tag);
        logic [31:0] v;
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall()));
        chk({tag, "_empty"}, 32'(empty), 32'(fq.size() == 0));
        if (exp_rd(v)) chk({tag, "_rd"}, rd, v);
    endtask

    // One clock: check outputs mid-cycle, then apply drain-before-enqueue to the model.
    task automatic cyc(string tag = "cyc");
        bit s;
        @(negedge clk);
        check_outs(tag);
        s = exp_stall();
        @(posedge clk);
        if (fq.size() != 0) begin
            mm[fq[0].w] = fq[0].d;
            kn[fq[0].w] = 1;
            void'(fq.pop_front());
        end
        if (!s)
            for (int j = 0; j < need_of(); j++)
                fq.push_back(ent_t'{(word_of(a) + j) % MW, vwe ? vwd[j] : wd});
        #1;
    endtask

    task automatic idle(int n);
        we  = 0;
        vwe = 0;
        repeat (n) cyc("idle");
    endtask

    task automatic read_chk(string tag, logic [31:0] addr);
        logic [31:0] v;
        a = addr;
        #1;
        if (exp_rd(v)) chk(tag, rd, v);
    endtask

    initial begin
        foreach (vwd[i]) vwd[i] = 0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        for (int w = 0; w < MW; w++) begin
            we = 1;
            a  = 32'(w * 4);
            wd = $urandom;
            cyc("pre");
        end
        idle(3);

        we = 1; a = 32'h10; wd = 32'hDEADBEEF;
        cyc("t1");
        we = 0;
        #1;
        chk("t1_empty0", 32'(empty), 32'd0);
        cyc("t1b");
        chk("t1_empty1", 32'(empty), 32'd1);
        chk("t1_rd", rd, 32'hDEADBEEF);

`ifdef DMEM_FWD_EN
        vwe = 1; a = 32'h80;
        foreach (vwd[i]) vwd[i] = $urandom;
        cyc("f0");
        vwe = 0; we = 1; a = 32'h20; wd = 32'h11111111;
        cyc("f1");
        wd = 32'h22222222;
        cyc("f2");
        we = 0;
        #1;
        chk("fwd_rd", rd, 32'h22222222);
        idle(8);
`else
        we = 1; a = 32'h40; wd = 32'h5A5A0040;
        cyc("h0");
        we = 0;
        #1;
        chk("haz_stall", 32'(stall), 32'd1);
        cyc("h1");
        chk("haz_clear", 32'(stall), 32'd0);
        chk("haz_rd", rd, 32'h5A5A0040);
`endif

        vwe = 1; a = 32'hF8;
        foreach (vwd[i]) vwd[i] = 32'hA0 + i;
        cyc("v0");
        idle(6);
        for (int i = 0; i < 5; i++) begin
            a = 32'hF8 + 32'(4 * i);
            #1;
            chk("vec_rd", rd, 32'hA0 + i);
        end
        @(posedge clk);
        #1;

        vwe = 1; a = 32'h80;
        foreach (vwd[i]) vwd[i] = $urandom;
        cyc("fill0");
        vwe = 0;
        cyc("fill1");
        vwe = 1; a = 32'h0;
        foreach (vwd[i]) vwd[i] = $urandom;
        #1;
        chk("fill_stall", 32'(stall), 32'd1);
        cyc("fill2");
        chk("fill_accept", 32'(stall), 32'd0);
        cyc("fill3");
        vwe = 0; we = 1; a = 32'hC0; wd = $urandom;
        #1;
        chk("fill7_scalar", 32'(stall), 32'd0);
        cyc("fill4");
        idle(10);

        vwe = 1; a = 32'hA0;
        foreach (vwd[i]) vwd[i] = $urandom;
        cyc("r0");
        idle(2);
        vwe = 1; a = 32'h140;
        foreach (vwd[i]) vwd[i] = $urandom;
        cyc("r1");
        idle(1);
        vwe = 1; a = 32'h0;
        #1;
        chk("prerst_stall", 32'(stall), 32'd1);
        reset = 1;
        fq.delete();
        #1;
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_stall", 32'(stall), 32'd0);
        vwe = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            read_chk("rst_w40", 32'hA0 + 32'(4 * i));
            read_chk("rst_w16", 32'h140 + 32'(4 * i));
        end
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom);
            vwe = $urandom_range(0, 3) == 0;
            a   = ($urandom & 32'hFFFFFF00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            wd  = $urandom;
            foreach (vwd[i]) vwd[i] = $urandom;
            cyc("rnd");
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
